// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM states, access size codes and byte-lane helpers.
// The lane helpers are pure functions, so completers can reuse them for strobe merge.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETUP  = 2'b01,
        ST_ACCESS = 2'b10,
        ST_RESP   = 2'b11
    } state_t;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    function automatic logic lane_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SIZE_B:  bad = 1'b0;
            SIZE_H:  bad = addr_lo[0];
            SIZE_W:  bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] lane_strobe(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] stb;
        case (size)
            SIZE_B:  stb = 4'b0001 << addr_lo;
            SIZE_H:  stb = addr_lo[1] ? 4'b1100 : 4'b0011;
            SIZE_W:  stb = 4'b1111;
            default: stb = 4'b0000;
        endcase
        return stb;
    endfunction

    function automatic logic [31:0] lane_steer(input logic [1:0] size, input logic [1:0] addr_lo,
                                               input logic [31:0] wdata);
        logic [31:0] lanes;
        case (size)
            SIZE_B:  lanes = {24'h0, wdata[7:0]} << {addr_lo, 3'b000};
            SIZE_H:  lanes = {16'h0, wdata[15:0]} << {addr_lo[1], 4'b0000};
            SIZE_W:  lanes = wdata;
            default: lanes = 32'h0;
        endcase
        return lanes;
    endfunction

    function automatic logic [31:0] lane_extract(input logic [1:0] size, input logic [1:0] addr_lo,
                                                 input logic is_unsigned, input logic [31:0] rdata);
        logic [31:0] sh;
        logic [31:0] ext;
        sh = rdata >> {addr_lo, 3'b000};
        case (size)
            SIZE_B:  ext = is_unsigned ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            SIZE_H:  ext = is_unsigned ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: ext = rdata;
        endcase
        return ext;
    endfunction

    // Completer side: fold strobed write lanes into an existing word.
    function automatic logic [31:0] lane_merge(input logic [31:0] old_word, input logic [31:0] new_lanes,
                                               input logic [3:0] stb);
        logic [31:0] mask;
        mask = {{8{stb[3]}}, {8{stb[2]}}, {8{stb[1]}}, {8{stb[0]}}};
        return (old_word & ~mask) | (new_lanes & mask);
    endfunction

endpackage

// File: rtl/apb_lane.sv
// Byte-lane steering, strobe generation, alignment check and load extraction.
// Latency: purely combinational. Backpressure: none, no state.
module apb_lane
    import apb_pkg::*;
(
    input  logic [1:0]  wr_size,
    input  logic [1:0]  wr_addr_lo,
    input  logic        wr_write,
    input  logic [31:0] wr_data,
    output logic [31:0] wr_lanes,
    output logic [3:0]  wr_stb,
    output logic        wr_misaligned,
    input  logic [1:0]  rd_size,
    input  logic [1:0]  rd_addr_lo,
    input  logic        rd_unsigned,
    input  logic [31:0] rd_data,
    output logic [31:0] rd_ext
);

    // Loads drive no strobes and an all-zero data bus.
    assign wr_lanes      = wr_write ? lane_steer(wr_size, wr_addr_lo, wr_data) : 32'h0;
    assign wr_stb        = wr_write ? lane_strobe(wr_size, wr_addr_lo) : 4'b0000;
    assign wr_misaligned = lane_misaligned(wr_size, wr_addr_lo);
    assign rd_ext        = lane_extract(rd_size, rd_addr_lo, rd_unsigned, rd_data);

endmodule

// File: rtl/apb_initiator.sv
// APB requester: one load/store in, one SETUP/ACCESS transfer out, one response pulse back.
// Latency: accept->resp 3 cycles plus wait states; misaligned/illegal requests respond next cycle.
// Backpressure: req_ready only in IDLE; response pulse has no backpressure; ACCESS stalls on pready.
module apb_initiator
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pdata,
    output logic [3:0]            pstb,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  perr
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W:0] TO_VAL = (CNT_W + 1)'(TIMEOUT);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W:0]         cnt_inc;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [1:0]             size_q, size_d;
    logic                   uns_q, uns_d;
    logic                   write_q, write_d;
    logic [DATA_WIDTH-1:0]  pdata_q, pdata_d;
    logic [3:0]             pstb_q, pstb_d;
    logic                   psel_q, psel_d;
    logic                   penable_q, penable_d;
    logic                   resp_vld_q, resp_vld_d;
    logic [DATA_WIDTH-1:0]  resp_rdata_q, resp_rdata_d;
    logic                   resp_err_q, resp_err_d;

    logic [31:0] st_lanes;
    logic [3:0]  st_stb;
    logic        st_misaligned;
    logic [31:0] ld_ext;

    apb_lane u_lane (
        .wr_size       (req_size),
        .wr_addr_lo    (req_addr[1:0]),
        .wr_write      (req_write),
        .wr_data       (req_wdata),
        .wr_lanes      (st_lanes),
        .wr_stb        (st_stb),
        .wr_misaligned (st_misaligned),
        .rd_size       (size_q),
        .rd_addr_lo    (addr_q[1:0]),
        .rd_unsigned   (uns_q),
        .rd_data       (prdata),
        .rd_ext        (ld_ext)
    );

    assign cnt_inc = {1'b0, cnt_q} + (CNT_W + 1)'(1);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        size_d       = size_q;
        uns_d        = uns_q;
        write_d      = write_q;
        pdata_d      = pdata_q;
        pstb_d       = pstb_q;
        psel_d       = 1'b0;
        penable_d    = 1'b0;
        resp_vld_d   = 1'b0;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    write_d = req_write;
                    pdata_d = st_lanes;
                    pstb_d  = st_stb;
                    if (st_misaligned) begin
                        state_d    = ST_RESP;
                        resp_vld_d = 1'b1;
                        resp_err_d = 1'b1;
                    end else begin
                        state_d = ST_SETUP;
                        psel_d  = 1'b1;
                        cnt_d   = '0;
                    end
                end
            end
            ST_SETUP: begin
                state_d   = ST_ACCESS;
                psel_d    = 1'b1;
                penable_d = 1'b1;
            end
            ST_ACCESS: begin
                // A completion in the last allowed cycle beats the timeout.
                if (pready || perr) begin
                    state_d      = ST_RESP;
                    resp_vld_d   = 1'b1;
                    resp_err_d   = perr;
                    resp_rdata_d = (!write_q && !perr) ? ld_ext : '0;
                end else if (TIMEOUT != 0 && cnt_inc == TO_VAL) begin
                    state_d    = ST_RESP;
                    resp_vld_d = 1'b1;
                    resp_err_d = 1'b1;
                end else begin
                    psel_d    = 1'b1;
                    penable_d = 1'b1;
                    cnt_d     = cnt_inc[CNT_W-1:0];
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            size_q       <= SIZE_B;
            uns_q        <= 1'b0;
            write_q      <= 1'b0;
            pdata_q      <= '0;
            pstb_q       <= 4'b0000;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            resp_vld_q   <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            write_q      <= write_d;
            pdata_q      <= pdata_d;
            pstb_q       <= pstb_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            resp_vld_q   <= resp_vld_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = resp_vld_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign paddr      = addr_q;
    assign pdata      = pdata_q;
    assign pstb       = pstb_q;
    assign psel       = psel_q;
    assign penable    = penable_q;
    assign pwrite     = write_q;

endmodule

// File: tb/tb_apb_initiator.sv
// Bench for apb_initiator (TIMEOUT=4): directed vector table, mid-transfer reset, and
// randomized transfers checked against a cycle-count/arithmetic reference model.
module tb_apb_initiator;

    localparam int TO = 4;

    logic        pclk = 1'b0;
    logic        presetn;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] paddr;
    logic [31:0] pdata;
    logic [3:0]  pstb;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] prdata;
    logic        pready;
    logic        perr;

    int checks = 0;
    int errors = 0;

    apb_initiator #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TO)) dut (
        .pclk(pclk), .presetn(presetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_write(req_write), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .paddr(paddr), .pdata(pdata), .pstb(pstb), .psel(psel), .penable(penable),
        .pwrite(pwrite), .prdata(prdata), .pready(pready), .perr(perr)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        write;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] prd;
        int          waits;
        int          perr_at;
        logic        err;
        logic [31:0] rdata;
        logic [31:0] pdata;
        logic [3:0]  pstb;
        int          r;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---- reference model: plain arithmetic on byte offsets ----
    function automatic logic m_mis(input logic [31:0] addr, input logic [1:0] size);
        int nb;
        if (size == 2'd3) return 1'b1;
        nb = 1 << size;
        return (addr % nb) != 0;
    endfunction

    function automatic logic [31:0] m_mask(input logic [1:0] size);
        if (size == 2'd2) return 32'hFFFF_FFFF;
        return (32'd1 << (8 * (1 << size))) - 32'd1;
    endfunction

    function automatic logic [31:0] m_pdata(input logic [31:0] addr, input logic [1:0] size,
                                            input logic [31:0] wdata);
        return (wdata & m_mask(size)) << (8 * (addr % 4));
    endfunction

    function automatic logic [3:0] m_pstb(input logic [31:0] addr, input logic [1:0] size);
        int nb;
        nb = 1 << size;
        return 4'(((1 << nb) - 1) << (addr % 4));
    endfunction

    function automatic logic [31:0] m_extract(input logic [31:0] addr, input logic [1:0] size,
                                              input logic uns, input logic [31:0] prd);
        logic [31:0] mask;
        logic [31:0] v;
        int          top;
        mask = m_mask(size);
        v    = (prd >> (8 * (addr % 4))) & mask;
        top  = 8 * (1 << size) - 1;
        if (!uns && size != 2'd2 && v[top]) v = v | ~mask;
        return v;
    endfunction

    // Runs one request from IDLE to the IDLE cycle after its response.
    // exp_r is the cycle (after the accept edge) in which resp_valid must be high.
    task automatic run_xfer(input string name, input vec_t v);
        chk({name, " ready_idle"}, req_ready, 1);
        req_valid    = 1'b1;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
        req_write    = v.write;
        req_size     = v.size;
        req_unsigned = v.uns;
        prdata       = v.prd;
        @(posedge pclk); #1;
        for (int c = 1; c <= v.r; c++) begin
            logic e_sel;
            logic e_pen;
            logic e_rv;
            e_sel = (v.r > 1) && (c < v.r);
            e_pen = e_sel && (c >= 2);
            e_rv  = (c == v.r);
            chk($sformatf("%s c%0d sel/en/rv/rdy", name, c), {psel, penable, resp_valid, req_ready},
                {e_sel, e_pen, e_rv, 1'b0});
            if (v.r > 1 && (c == 1 || c == v.r - 1)) begin
                chk($sformatf("%s c%0d paddr", name, c), paddr, v.addr);
                chk($sformatf("%s c%0d pwrite", name, c), pwrite, v.write);
                chk($sformatf("%s c%0d pstb", name, c), pstb, v.pstb);
                if (v.write) chk($sformatf("%s c%0d pdata", name, c), pdata, v.pdata);
            end
            if (c == v.r) begin
                chk({name, " resp_err"}, resp_err, v.err);
                chk({name, " resp_rdata"}, resp_rdata, v.rdata);
            end
            if (c < v.r) begin
                req_valid    = 1'b1;
                req_addr     = $urandom;
                req_wdata    = $urandom;
                req_write    = 1'($urandom);
                req_size     = 2'($urandom);
                req_unsigned = 1'($urandom);
            end else begin
                req_valid = 1'b0;
            end
            pready = (c >= 2) && (c < v.r) && ((c - 1) == v.waits + 1);
            perr   = (c >= 2) && (c < v.r) && ((c - 1) == v.perr_at);
            @(posedge pclk); #1;
        end
        pready = 1'b0;
        perr   = 1'b0;
    endtask

    function automatic vec_t model(input vec_t v);
        vec_t o;
        int   d;
        o       = v;
        o.pdata = v.write ? m_pdata(v.addr, v.size, v.wdata) : 32'h0;
        o.pstb  = v.write ? m_pstb(v.addr, v.size) : 4'h0;
        if (m_mis(v.addr, v.size)) begin
            o.err = 1'b1; o.rdata = 32'h0; o.r = 1;
        end else begin
            d = v.waits + 1;
            if (v.perr_at != 0 && v.perr_at < d) d = v.perr_at;
            if (d > TO) begin
                o.err = 1'b1; o.r = 2 + TO;
            end else begin
                o.err = (v.perr_at == d); o.r = 2 + d;
            end
            o.rdata = (!v.write && !o.err) ? m_extract(v.addr, v.size, v.uns, v.prd) : 32'h0;
        end
        return o;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rv_seen;
        vec_t rv;
        presetn = 1'b0;
        req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_write = 1'b0;
        req_size = 2'b00; req_unsigned = 1'b0; prdata = '0; pready = 1'b0; perr = 1'b0;

        //            addr          wdata         wr    sz     uns   prdata        wt pe  err   rdata         pdata         pstb  r
        tbl[0]  = '{32'h8000_0010, 32'hDEAD_BEEF, 1'b1, 2'd2, 1'b0, 32'h0,         0, 0, 1'b0, 32'h0,         32'hDEAD_BEEF, 4'hF, 3};
        tbl[1]  = '{32'h0100_0002, 32'h0000_00A5, 1'b1, 2'd0, 1'b0, 32'h0,         0, 0, 1'b0, 32'h0,         32'h00A5_0000, 4'h4, 3};
        tbl[2]  = '{32'h8000_0002, 32'h0,         1'b0, 2'd1, 1'b0, 32'h8001_1234, 2, 0, 1'b0, 32'hFFFF_8001, 32'h0,         4'h0, 5};
        tbl[3]  = '{32'h8000_0002, 32'h0,         1'b0, 2'd1, 1'b1, 32'h8001_1234, 2, 0, 1'b0, 32'h0000_8001, 32'h0,         4'h0, 5};
        tbl[4]  = '{32'h8000_0001, 32'h0,         1'b0, 2'd2, 1'b0, 32'h1234_5678, 0, 0, 1'b1, 32'h0,         32'h0,         4'h0, 1};
        tbl[5]  = '{32'h0000_0800, 32'h0,         1'b0, 2'd2, 1'b0, 32'hCAFE_F00D, 5, 1, 1'b1, 32'h0,         32'h0,         4'h0, 3};
        tbl[6]  = '{32'h8000_0000, 32'h0,         1'b0, 2'd2, 1'b0, 32'h5555_AAAA, 20, 0, 1'b1, 32'h0,        32'h0,         4'h0, 6};
        tbl[7]  = '{32'h4000_0004, 32'h1122_3344, 1'b1, 2'd2, 1'b0, 32'h0,         1, 2, 1'b1, 32'h0,         32'h1122_3344, 4'hF, 4};
        tbl[8]  = '{32'h0000_0003, 32'h0,         1'b0, 2'd0, 1'b0, 32'h80FF_FFFF, 0, 0, 1'b0, 32'hFFFF_FF80, 32'h0,         4'h0, 3};
        tbl[9]  = '{32'h0000_0004, 32'h0,         1'b0, 2'd3, 1'b0, 32'h0,         0, 0, 1'b1, 32'h0,         32'h0,         4'h0, 1};
        tbl[10] = '{32'h2000_0006, 32'hFFFF_BEEF, 1'b1, 2'd1, 1'b0, 32'h0,         3, 0, 1'b0, 32'h0,         32'hBEEF_0000, 4'hC, 6};
        tbl[11] = '{32'h0000_0001, 32'h0,         1'b0, 2'd0, 1'b1, 32'h0000_9A00, 0, 0, 1'b0, 32'h0000_009A, 32'h0,         4'h0, 3};

        repeat (2) @(posedge pclk);
        #1;
        chk("rst psel", psel, 0);
        chk("rst penable", penable, 0);
        chk("rst pwrite", pwrite, 0);
        chk("rst paddr", paddr, 0);
        chk("rst pdata", pdata, 0);
        chk("rst pstb", pstb, 0);
        chk("rst resp_valid", resp_valid, 0);
        chk("rst resp_rdata", resp_rdata, 0);
        chk("rst resp_err", resp_err, 0);
        chk("rst req_ready", req_ready, 1);
        presetn = 1'b1;
        @(posedge pclk); #1;

        for (int i = 0; i < 12; i++) run_xfer($sformatf("vec%0d", i), tbl[i]);

        // Reset in the second ACCESS cycle of a never-ready transfer.
        req_valid = 1'b1; req_addr = 32'h8000_0000; req_write = 1'b0;
        req_size = 2'd2; req_unsigned = 1'b0;
        @(posedge pclk); #1;
        req_valid = 1'b0;
        chk("rstmid setup psel", psel, 1);
        @(posedge pclk); #1;
        chk("rstmid acc1 penable", penable, 1);
        @(posedge pclk); #1;
        chk("rstmid acc2 penable", penable, 1);
        presetn = 1'b0;
        #1;
        chk("rstmid psel async", psel, 0);
        chk("rstmid penable async", penable, 0);
        @(posedge pclk); #1;
        @(posedge pclk); #1;
        presetn = 1'b1;
        rv_seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (resp_valid || psel) rv_seen++;
            @(posedge pclk); #1;
        end
        chk("rstmid no resp/psel after reset", 32'(rv_seen), 0);
        rv = '{32'h8000_0000, 32'h0, 1'b0, 2'd2, 1'b0, 32'h0BAD_F00D, 0, 0, 1'b0,
               32'h0BAD_F00D, 32'h0, 4'h0, 3};
        run_xfer("reissue", rv);

        for (int i = 0; i < 60; i++) begin
            vec_t v;
            v.addr  = $urandom;
            v.size  = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0 && v.size != 2'd3)
                v.addr = v.addr & ~((32'd1 << v.size) - 32'd1);
            v.wdata   = $urandom;
            v.write   = 1'($urandom);
            v.uns     = 1'($urandom);
            v.prd     = $urandom;
            v.waits   = $urandom_range(0, 5);
            v.perr_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 6)) : 0;
            v.err = 1'b0; v.rdata = '0; v.pdata = '0; v.pstb = '0; v.r = 0;
            run_xfer($sformatf("rnd%0d", i), model(v));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
